// File: rtl/eth_tx_line_pkg.sv
// Shared state encoding and 20 MHz timing defaults for the 10BASE-T transmit line coder.
package eth_tx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALF1 = 3'd1,
      HALF2 = 3'd2,
      TPIDL = 3'd3,
      NLP   = 3'd4
   } tx_state_e;

   localparam int DEF_TP_IDL_LEN = 5;       // 250 ns
   localparam int DEF_NLP_LEN    = 2;       // 100 ns
   localparam int DEF_NLP_PERIOD = 320000;  // 16 ms
   localparam int DEF_NLP_W      = 19;

endpackage

// File: rtl/eth_tx_line_if.sv
// NRZ bit handshake between the serial frame generator (master) and the line coder (slave).
interface eth_tx_line_if;

   logic tx_en;
   logic tx_bit;
   logic tx_bit_rd;

   modport master (output tx_en, output tx_bit, input tx_bit_rd);
   modport slave  (input tx_en, input tx_bit, output tx_bit_rd);

endinterface

// File: rtl/eth_tx_line_nlp_timer.sv
// Link-pulse timer: idle-interval counter plus pulse-length counter.
// Present only when ETH_TX_LINE_NLP_EN is defined.
`ifdef ETH_TX_LINE_NLP_EN
module eth_nlp_timer #(
   parameter int NLP_LEN    = 2,
   parameter int NLP_PERIOD = 320000,
   parameter int NLP_W      = 19
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic clear,
   output logic nlp_fire
);

   localparam int PLS_W = (NLP_LEN > 1) ? $clog2(NLP_LEN) : 1;
   localparam logic [NLP_W-1:0] IVL_LAST = NLP_W'(NLP_PERIOD - 1);
   localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(NLP_LEN - 1);

   logic [NLP_W-1:0] ivl_q, ivl_d;
   logic [PLS_W-1:0] pls_q, pls_d;
   logic             act_q, act_d;
   logic             start;

   // nlp_fire requests the pulse from IDLE and stays high until its last cycle
   assign start    = idle && (ivl_q == IVL_LAST);
   assign nlp_fire = start || (act_q && (pls_q != PLS_LAST));

   always_comb begin
      ivl_d = ivl_q;
      pls_d = pls_q;
      act_d = act_q;
      if (clear) begin
         ivl_d = '0;
         pls_d = '0;
         act_d = 1'b0;
      end else begin
         if (!idle || start) ivl_d = '0;
         else                ivl_d = ivl_q + NLP_W'(1);
         if (start) begin
            act_d = 1'b1;
            pls_d = '0;
         end else if (act_q) begin
            if (pls_q == PLS_LAST) begin
               act_d = 1'b0;
               pls_d = '0;
            end else begin
               pls_d = pls_q + PLS_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ivl_q <= '0;
         pls_q <= '0;
         act_q <= 1'b0;
      end else begin
         ivl_q <= ivl_d;
         pls_q <= pls_d;
         act_q <= act_d;
      end
   end

endmodule
`endif

// File: rtl/eth_tx_line.sv
// 10BASE-T Manchester line coder with TP_IDL tail; link pulses while idle when
// ETH_TX_LINE_NLP_EN is defined.
module eth_tx_line
   import eth_tx_pkg::*;
#(
   parameter int TP_IDL_LEN = DEF_TP_IDL_LEN
`ifdef ETH_TX_LINE_NLP_EN
   ,
   parameter int NLP_LEN    = DEF_NLP_LEN,
   parameter int NLP_PERIOD = DEF_NLP_PERIOD,
   parameter int NLP_W      = DEF_NLP_W
`endif
) (
   input  logic         clk,
   input  logic         rst,
   eth_tx_line_if.slave tx_if,
   output logic         td_p,
   output logic         td_n,
   output logic         tx_busy
);

   localparam int TL_W = (TP_IDL_LEN > 1) ? $clog2(TP_IDL_LEN) : 1;
   localparam logic [TL_W-1:0] TL_LAST = TL_W'(TP_IDL_LEN - 1);

   tx_state_e       state_q;
   logic            bit_q;
   logic [TL_W-1:0] tail_q;
   logic            td_p_q, td_n_q, busy_q;

   assign td_p    = td_p_q;
   assign td_n    = td_n_q;
   assign tx_busy = busy_q;

   // A bit is only accepted at the start of a bit period
   assign tx_if.tx_bit_rd = ((state_q == IDLE) || (state_q == HALF2)) && tx_if.tx_en;

`ifdef ETH_TX_LINE_NLP_EN
   logic nlp_fire;
   logic nlp_idle;
   logic nlp_clear;

   assign nlp_idle  = (state_q == IDLE) && !tx_if.tx_en;
   assign nlp_clear = state_q inside {HALF1, HALF2, TPIDL};

   eth_nlp_timer #(
      .NLP_LEN    (NLP_LEN),
      .NLP_PERIOD (NLP_PERIOD),
      .NLP_W      (NLP_W)
   ) u_nlp (
      .clk      (clk),
      .rst      (rst),
      .idle     (nlp_idle),
      .clear    (nlp_clear),
      .nlp_fire (nlp_fire)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= 1'b0;
         tail_q  <= '0;
         td_p_q  <= 1'b0;
         td_n_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tx_if.tx_en) begin
                  state_q <= HALF1;
                  bit_q   <= tx_if.tx_bit;
                  td_p_q  <= ~tx_if.tx_bit;
                  td_n_q  <= tx_if.tx_bit;
                  busy_q  <= 1'b1;
               end
`ifdef ETH_TX_LINE_NLP_EN
               else if (nlp_fire) begin
                  state_q <= NLP;
                  td_p_q  <= 1'b1;
                  td_n_q  <= 1'b0;
               end
`endif
            end
            HALF1: begin
               state_q <= HALF2;
               td_p_q  <= bit_q;
               td_n_q  <= ~bit_q;
            end
            HALF2: begin
               if (tx_if.tx_en) begin
                  state_q <= HALF1;
                  bit_q   <= tx_if.tx_bit;
                  td_p_q  <= ~tx_if.tx_bit;
                  td_n_q  <= tx_if.tx_bit;
               end else begin
                  state_q <= TPIDL;
                  tail_q  <= '0;
                  td_p_q  <= 1'b1;
                  td_n_q  <= 1'b0;
               end
            end
            TPIDL: begin
               if (tail_q == TL_LAST) begin
                  state_q <= IDLE;
                  td_p_q  <= 1'b0;
                  td_n_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  tail_q <= tail_q + TL_W'(1);
               end
            end
`ifdef ETH_TX_LINE_NLP_EN
            NLP: begin
               if (!nlp_fire) begin
                  state_q <= IDLE;
                  td_p_q  <= 1'b0;
                  td_n_q  <= 1'b0;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
               td_p_q  <= 1'b0;
               td_n_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_line.sv
// Bench for eth_tx_line: reset, table-driven frames, random frames against a
// waveform model, reset mid-frame, and idle-line behaviour for either build.
`timescale 1ns/1ps
module tb_eth_tx_line;

   localparam int TPL = 5;
`ifdef ETH_TX_LINE_NLP_EN
   localparam int NLPP = 20;
   localparam int NLPL = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic td_p, td_n, tx_busy;

   eth_tx_line_if bus ();

   eth_tx_line #(
      .TP_IDL_LEN (TPL)
`ifdef ETH_TX_LINE_NLP_EN
      ,
      .NLP_LEN    (NLPL),
      .NLP_PERIOD (NLPP),
      .NLP_W      (5)
`endif
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_if   (bus),
      .td_p    (td_p),
      .td_n    (td_n),
      .tx_busy (tx_busy)
   );

   always #25 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Upstream model: presents bits MSB-first (bits[n-1] first), advances on tx_bit_rd.
   // Samples the line each negedge; sample 0 is the leftmost captured bit.
   task automatic do_frame(input logic [15:0] bits, input int n, input bit late, input int ncap,
                           output logic [63:0] gp, output logic [63:0] gn,
                           output logic [63:0] gb, output int rdc);
      int idx;
      bit rd;
      bit pend;
      idx = 0; pend = 0;
      gp = '0; gn = '0; gb = '0; rdc = 0;
      bus.tx_en  = 1'b1;
      bus.tx_bit = bits[n-1];
      for (int c = 0; c < ncap; c++) begin
         @(negedge clk);
         gp = {gp[62:0], td_p};
         gn = {gn[62:0], td_n};
         gb = {gb[62:0], tx_busy};
         rd = bus.tx_bit_rd;
         if (rd) rdc++;
         if (pend) begin
            bus.tx_en = 1'b0;
            pend = 0;
         end
         @(posedge clk);
         #1;
         if (rd) begin
            idx++;
            if (idx < n) begin
               bus.tx_bit = bits[n-1-idx];
            end else if (late) begin
               bus.tx_bit = ~bus.tx_bit;
               pend = 1;
            end else begin
               bus.tx_en = 1'b0;
            end
         end
      end
      bus.tx_en = 1'b0;
   endtask

   // Expected line waveform from the coding rules
   function automatic void model(input logic [15:0] bits, input int n, input bit pre, input int ncap,
                                 output logic [63:0] ep, output logic [63:0] en, output logic [63:0] eb);
      logic qp[$];
      logic qn[$];
      logic qb[$];
      logic b;
      if (pre) begin
         qp.push_back(1'b1); qn.push_back(1'b0); qb.push_back(1'b0);
      end
      qp.push_back(1'b0); qn.push_back(1'b0); qb.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         b = bits[n-1-i];
         qp.push_back(~b); qn.push_back(b);  qb.push_back(1'b1);
         qp.push_back(b);  qn.push_back(~b); qb.push_back(1'b1);
      end
      for (int i = 0; i < TPL; i++) begin
         qp.push_back(1'b1); qn.push_back(1'b0); qb.push_back(1'b1);
      end
      while (qp.size() < ncap) begin
         qp.push_back(1'b0); qn.push_back(1'b0); qb.push_back(1'b0);
      end
      ep = '0; en = '0; eb = '0;
      for (int i = 0; i < ncap; i++) begin
         ep = {ep[62:0], qp[i]};
         en = {en[62:0], qn[i]};
         eb = {eb[62:0], qb[i]};
      end
   endfunction

   task automatic run_frame(input string tag, input logic [15:0] bits, input int n, input bit late,
                            input bit pre, output logic [63:0] gp, output logic [63:0] gn);
      logic [63:0] gb, ep, en, eb;
      int rdc;
      int ncap;
      ncap = (pre ? 2 : 1) + 2 * n + TPL + 3;
      do_frame(bits, n, late, ncap, gp, gn, gb, rdc);
      model(bits, n, pre, ncap, ep, en, eb);
      $display("frame %s: n=%0d bits=%b late=%0d td_p=%h td_n=%h busy=%h rd_pulses=%0d",
               tag, n, bits, late, gp, gn, gb, rdc);
      check({tag, "_td_p"}, gp, ep);
      check({tag, "_td_n"}, gn, en);
      check({tag, "_busy"}, gb, eb);
      check({tag, "_rd_count"}, 64'(rdc), 64'(n));
   endtask

   typedef struct {
      logic [15:0] bits;
      int          n;
      bit          late;
      logic [63:0] xp;
      logic [63:0] xn;
   } vec_t;

   vec_t vt[4];

   initial begin
      logic [63:0] gp, gn;
      logic [15:0] rbits;
      int          rn;
      int          bad;
      bit          found;
`ifdef ETH_TX_LINE_NLP_EN
      int          mism, rises, side;
      logic        prev;
`endif

      vt[0] = '{bits: 16'b1011, n: 4, late: 1'b0,
                xp: 64'b00110010111111000, xn: 64'b01001101000000000};
      vt[1] = '{bits: 16'b100,  n: 3, late: 1'b1,
                xp: 64'b001101011111000,   xn: 64'b010010100000000};
      vt[2] = '{bits: 16'b0,    n: 1, late: 1'b0,
                xp: 64'b01011111000,       xn: 64'b00100000000};
      vt[3] = '{bits: 16'b1,    n: 1, late: 1'b1,
                xp: 64'b00111111000,       xn: 64'b01000000000};

      // Reset held with tx_en high
      bus.tx_en  = 1'b1;
      bus.tx_bit = 1'b0;
      rst        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset_out%0d", i), 64'({td_p, td_n, tx_busy}), 64'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      run_frame("post_reset", 16'b10, 2, 1'b0, 1'b0, gp, gn);

      for (int i = 0; i < 4; i++) begin
         run_frame($sformatf("vec%0d", i), vt[i].bits, vt[i].n, vt[i].late, 1'b0, gp, gn);
         check($sformatf("vec%0d_lit_td_p", i), gp, vt[i].xp);
         check($sformatf("vec%0d_lit_td_n", i), gn, vt[i].xn);
      end

      for (int i = 0; i < 16; i++) begin
         rbits = 16'($urandom);
         rn    = $urandom_range(12, 1);
         run_frame($sformatf("rand%0d", i), rbits, rn, 1'($urandom_range(1, 0)), 1'b0, gp, gn);
         repeat ($urandom_range(4, 0)) @(posedge clk);
         #1;
      end

      // Reset during HALF2 of the third bit of an all-ones frame
      @(posedge clk);
      #1;
      bus.tx_en  = 1'b1;
      bus.tx_bit = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("pre_reset_half2", 64'({td_p, td_n, tx_busy}), 64'b101);
      rst = 1'b1;
      #1;
      check("async_reset_out", 64'({td_p, td_n, tx_busy}), 64'd0);
      bus.tx_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (td_p !== 1'b0 || td_n !== 1'b0 || tx_busy !== 1'b0) bad++;
      end
      $display("reset mid-frame: %0d non-silent samples after release", bad);
      check("no_tail_after_reset", 64'(bad), 64'd0);
      @(posedge clk);
      #1;
      run_frame("after_reset", 16'b011, 3, 1'b0, 1'b0, gp, gn);

`ifdef ETH_TX_LINE_NLP_EN
      // Idle line: pulse at sample k when (k-20) mod 22 < 2 after reset release
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mism = 0; rises = 0; side = 0; prev = 1'b0;
      for (int k = 0; k < 100; k++) begin
         bit e;
         @(negedge clk);
         e = (k >= NLPP) && (((k - NLPP) % (NLPP + NLPL)) < NLPL);
         if (td_p !== e) mism++;
         if (td_n !== 1'b0 || tx_busy !== 1'b0) side++;
         if (td_p === 1'b1 && prev === 1'b0) rises++;
         prev = td_p;
      end
      $display("nlp idle: mismatches=%0d rises=%0d side=%0d", mism, rises, side);
      check("nlp_pattern", 64'(mism), 64'd0);
      check("nlp_rises", 64'(rises), 64'd4);
      check("nlp_td_n_busy", 64'(side), 64'd0);

      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (td_p === 1'b1) found = 1;
      end
      check("nlp_wait_pulse", 64'(found), 64'd1);
      run_frame("nlp_defer", 16'b01, 2, 1'b0, 1'b1, gp, gn);
`else
      bad = 0;
      found = 1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (td_p !== 1'b0 || td_n !== 1'b0) bad++;
      end
      $display("idle line: %0d non-silent samples in 1000 cycles", bad);
      check("idle_silent", 64'(bad), 64'd0);
      check("idle_busy_low", 64'(tx_busy), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
